cr_cfg_master: RTL
==================

# cr_cfg_master

Wishbone initiator that programs the cognitive-radio register block: a standard-select write followed by the allocation-vector words that fill the 4096-bit allocation register. It sits between the control processor/sequencer and the CR register slave. It fetches vector words from a synchronous word memory, honours the slave's ACK back-pressure and watchdogs each bus transfer.

## Interface
- TMO_CYC, 64: max cycles a strobe may wait for ACK_I before the load aborts (range 2..255).
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle load request; sampled only in IDLE.
- STD_IN  in  2  standard to program; latched on accepted START.
- RD_ADR  out  7  word-memory read address.
- RD_DAT  in  32  word-memory data, valid exactly 1 cycle after RD_ADR.
- ADR_O  out  2  Wishbone address: 2'b00 = control, 2'b01 = vector.
- DAT_O  out  32  Wishbone write data.
- WE_O, STB_O, CYC_O  out  1 each  Wishbone write strobe set; always asserted together.
- ACK_I  in  1  slave acknowledge; combinational, may be high before STB_O.
- VEC_LD  out  1  one-cycle pulse that clears the slave's vector-word counter.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  sticky timeout flag; cleared by the next accepted START.

## Operation
- States: IDLE, CLR, WR_STD, FETCH, WR_VEC, FIN, ABORT.
- IDLE: START=1 latches std ← STD_IN, clears ERR, idx ← 0 → CLR. START in other states is ignored.
- CLR: VEC_LD=1 for exactly this cycle → WR_STD.
- WR_STD: CYC/STB/WE=1, ADR_O=00, DAT_O={30'b0,std}; hold until ACK_I=1. On ACK: std=3 → FIN, else → FETCH.
- Word count N from std: 0→4, 1→16, 2→128, 3→0. Vector writes are never issued for std=3.
- FETCH: RD_ADR=idx, one cycle, no strobe → WR_VEC.
- WR_VEC: DAT_O=RD_DAT registered at FETCH exit and held stable. CYC/STB/WE=1, ADR_O=01. On ACK: idx==N-1 → FIN, else idx ← idx+1 → FETCH.
- Words are sent in ascending idx. Word 0 therefore ends in the most-significant 32 bits of the slave's 4096-bit register after a full 128-word load.
- FIN: DONE=1 for one cycle → IDLE.
- Watchdog: 8-bit wait counter. It clears on entry to WR_STD/WR_VEC and on every ACK, and increments each strobed cycle without ACK. Reaching TMO_CYC → ABORT.
- ABORT: strobes drop, ERR ← 1 → IDLE. The ABORT cycle does not pulse DONE.
- Reset: state IDLE, idx=0, std=0, counter 0. All outputs 0: RD_ADR=0, DAT_O=0, ADR_O=0, WE/STB/CYC=0, VEC_LD=0, BUSY=0, DONE=0, ERR=0. Reset mid-transfer drops strobes immediately (asynchronous).

## Timing
- All outputs are registered except RD_ADR, which is driven from idx.
- ACK_I is sampled on the rising edge while STB_O=1. If ACK_I is already high in the first strobe cycle, that cycle completes the transfer: one bus cycle per write.
- No back-to-back strobes: at least one non-strobe cycle (FETCH) separates vector writes. Minimum cost is 2 cycles per word.
- Zero-wait-state slave, from accepted START to DONE: std=0 → 1+1+8+1 = 11 cycles; std=3 → 3 cycles; std=2 → 259 cycles.
- STB_O, ADR_O and DAT_O must not change while a strobe is pending without ACK.
- ACK_I while STB_O=0 is ignored.
- Timeout boundary: with ACK_I stuck low, STB_O stays high for exactly TMO_CYC cycles, and ABORT follows in the next cycle.

## Test plan
- std=0, memory words 0..3 = 0xA0000000+i, zero-wait slave: one VEC_LD pulse; one control write DAT_O=0; four vector writes in order A0000000..A0000003; DONE at cycle 11; slave register low 128 bits = {A0000000,A0000001,A0000002,A0000003}.
- std=2, 128 words, slave inserting 3 wait states on every 10th write: all 128 writes complete; DAT_O stable throughout each wait; no ERR; DONE pulses once.
- std=3: only the control write with DAT_O=3; no STB_O with ADR_O=01; DONE at cycle 3.
- ACK_I held low during the 2nd vector write, TMO_CYC=8: STB_O high for exactly 8 cycles, then ERR=1, BUSY=0, no DONE; a following START clears ERR and a full load succeeds.
- RST_I asserted low during the 50th word of an std=2 load: all outputs 0 asynchronously. After release, START with std=1 yields VEC_LD then 17 writes and DONE.
- START pulsed while BUSY, and ACK_I high with no strobe: both ignored; transfer sequence and write count are unchanged.

Source files
------------

// File: rtl/cr_cfg_master.sv
// Wishbone initiator that programs the cognitive-radio register block:
// one standard-select control write, then the allocation-vector words
// fetched from a synchronous word memory, each bus transfer watchdogged.
module cr_cfg_master #(
  parameter int TMO_CYC = 64
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        START,
  input  logic [1:0]  STD_IN,
  output logic [6:0]  RD_ADR,
  input  logic [31:0] RD_DAT,
  output logic [1:0]  ADR_O,
  output logic [31:0] DAT_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I,
  output logic        VEC_LD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_WR_STD = 3'd2;
  localparam logic [2:0] S_FETCH  = 3'd3;
  localparam logic [2:0] S_WR_VEC = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;
  localparam logic [2:0] S_ABORT  = 3'd6;

  // Last strobe cycle the watchdog tolerates before giving up.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  // Index of the final vector word for a standard (std 3 sends none).
  function automatic logic [6:0] last_idx(input logic [1:0] s);
    case (s)
      2'd0:    last_idx = 7'd3;
      2'd1:    last_idx = 7'd15;
      2'd2:    last_idx = 7'd127;
      default: last_idx = 7'd0;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [1:0]  std_q, std_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        err_q, err_d;
  logic [1:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        stb_q, vld_q, busy_q, done_q;

  // Next-state, index, watchdog and bus-payload decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    std_d   = std_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          std_d   = STD_IN;
          err_d   = 1'b0;
          idx_d   = 7'd0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_WR_STD;
        wdog_d  = 8'd0;
        adr_d   = 2'b00;
        dat_d   = {30'd0, std_q};
      end
      S_WR_STD: begin
        if (ACK_I) begin
          wdog_d  = 8'd0;
          state_d = (std_q == 2'd3) ? S_FIN : S_FETCH;
        end else if (wdog_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_FETCH: begin
        state_d = S_WR_VEC;
        wdog_d  = 8'd0;
        adr_d   = 2'b01;
        dat_d   = RD_DAT;
      end
      S_WR_VEC: begin
        if (ACK_I) begin
          wdog_d = 8'd0;
          if (idx_q == last_idx(std_q)) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = S_FETCH;
          end
        end else if (wdog_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The memory is synchronous, so the address of the next word is
  // presented as soon as the index is decided; its data is then on
  // RD_DAT throughout FETCH and is captured into DAT_O at FETCH exit.
  assign RD_ADR = idx_d;

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      idx_q   <= 7'd0;
      std_q   <= 2'd0;
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
      adr_q   <= 2'b00;
      dat_q   <= 32'd0;
      stb_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      std_q   <= std_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      stb_q   <= (state_d == S_WR_STD) || (state_d == S_WR_VEC);
      vld_q   <= (state_d == S_CLR);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FIN);
    end
  end

  assign ADR_O  = adr_q;
  assign DAT_O  = dat_q;
  assign STB_O  = stb_q;
  assign CYC_O  = stb_q;
  assign WE_O   = stb_q;
  assign VEC_LD = vld_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;

endmodule
